// File: rtl/display_digit_mux.sv
// display_digit_mux
//   Time-multiplexes two 4-bit hex values onto one shared seven-segment
//   decoder for a dual-digit display. Each digit is preceded by a blanking
//   gap (all anodes off) so the previous value never ghosts onto the newly
//   enabled digit. Sequence: BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0 ...
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high; priority over en
//   en         : display enable; 0 holds the sequencer in BLANK0, all digits off
//   s0, s1     : hex values for digit 0 / digit 1
//   s_out      : value presented to the segment decoder (registered)
//   blank      : 1 = decoder segments must be forced off
//   an         : active-low digit enables, an[0] = digit 0, an[1] = digit 1
//   digit_sel  : index of the digit currently owned
//   frame_tick : one-cycle pulse on the first cycle of BLANK0 entered from SHOW1
module display_digit_mux #(
   parameter int unsigned DWELL_CYCLES = 24000,
   parameter int unsigned BLANK_CYCLES = 240,
   parameter int unsigned CNT_W        = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [3:0] s0,
   input  logic [3:0] s1,
   output logic [3:0] s_out,
   output logic       blank,
   output logic [1:0] an,
   output logic       digit_sel,
   output logic       frame_tick
);

   typedef enum logic [1:0] {
      BLANK0 = 2'd0,
      SHOW0  = 2'd1,
      BLANK1 = 2'd2,
      SHOW1  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       s_out_d;
   logic             blank_d;
   logic [1:0]       an_d;
   logic             digit_sel_d;
   logic             frame_tick_d;
   logic             last;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + 1'b1;
      s_out_d      = s_out;
      frame_tick_d = 1'b0;
      last         = 1'b0;

      // s_out follows the digit's input only while that digit is blanked,
      // so the value seen during SHOW is the one loaded on the last BLANK edge.
      case (state_q)
         BLANK0: begin
            s_out_d = s0;
            last    = (cnt_q == BLANK_LAST);
            if (last) state_d = SHOW0;
         end
         SHOW0: begin
            last = (cnt_q == DWELL_LAST);
            if (last) state_d = BLANK1;
         end
         BLANK1: begin
            s_out_d = s1;
            last    = (cnt_q == BLANK_LAST);
            if (last) state_d = SHOW1;
         end
         SHOW1: begin
            last = (cnt_q == DWELL_LAST);
            if (last) begin
               state_d      = BLANK0;
               frame_tick_d = 1'b1;
            end
         end
         default: state_d = BLANK0;
      endcase

      if (last) cnt_d = '0;

      // Disable wins over a coincident terminal count and suppresses the tick.
      if (!en) begin
         state_d      = BLANK0;
         cnt_d        = '0;
         frame_tick_d = 1'b0;
         s_out_d      = s0;
      end

      // Outputs are decoded from the next state so they register in step
      // with the state they describe.
      blank_d     = 1'b1;
      an_d        = 2'b11;
      digit_sel_d = 1'b0;
      case (state_d)
         SHOW0: begin
            blank_d = 1'b0;
            an_d    = 2'b10;
         end
         BLANK1: begin
            digit_sel_d = 1'b1;
         end
         SHOW1: begin
            blank_d     = 1'b0;
            an_d        = 2'b01;
            digit_sel_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= BLANK0;
         cnt_q      <= '0;
         s_out      <= '0;
         blank      <= 1'b1;
         an         <= 2'b11;
         digit_sel  <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         s_out      <= s_out_d;
         blank      <= blank_d;
         an         <= an_d;
         digit_sel  <= digit_sel_d;
         frame_tick <= frame_tick_d;
      end
   end

endmodule

// File: tb/tb_display_digit_mux.sv
// tb_display_digit_mux
//   Directed bench for display_digit_mux. A small instance (DWELL=4, BLANK=2)
//   covers the per-cycle sequence; a default-parameter instance checks the
//   full frame period and anode transition rules.
module tb_display_digit_mux;

   logic       clk = 1'b0;
   logic       reset, en;
   logic [3:0] s0, s1;
   logic [3:0] s_out;
   logic       blank, digit_sel, frame_tick;
   logic [1:0] an;

   logic       reset_d, en_d;
   logic [3:0] s_out_d;
   logic       blank_dd, digit_sel_d, frame_tick_d;
   logic [1:0] an_d;

   int errors = 0;
   int checks = 0;

   // {an, blank, digit_sel, frame_tick, s_out}
   logic [8:0] obs;
   assign obs = {an, blank, digit_sel, frame_tick, s_out};

   always #5 clk = ~clk;

   display_digit_mux #(
      .DWELL_CYCLES(4),
      .BLANK_CYCLES(2),
      .CNT_W(15)
   ) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .s0(s0),
      .s1(s1),
      .s_out(s_out),
      .blank(blank),
      .an(an),
      .digit_sel(digit_sel),
      .frame_tick(frame_tick)
   );

   display_digit_mux dut_def (
      .clk(clk),
      .reset(reset_d),
      .en(en_d),
      .s0(4'h1),
      .s1(4'h2),
      .s_out(s_out_d),
      .blank(blank_dd),
      .an(an_d),
      .digit_sel(digit_sel_d),
      .frame_tick(frame_tick_d)
   );

   function automatic logic [8:0] ev(input logic [1:0] a, input logic b,
                                     input logic d, input logic f,
                                     input logic [3:0] s);
      return {a, b, d, f, s};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en    = 1'b1;
      s0    = 4'h5;
      s1    = 4'h0;
      for (int c = 1; c <= 3; c++) begin
         step();
         checks++;
         if (obs !== ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h0)) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: got %h expected %h", c, obs,
                     ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h0));
         end
      end
   endtask

   task automatic test_steady_frame();
      logic [8:0] exp_t [14];
      exp_t[0]  = ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h0);
      exp_t[1]  = ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h3);
      exp_t[2]  = ev(2'b10, 1'b0, 1'b0, 1'b0, 4'h3);
      exp_t[3]  = ev(2'b10, 1'b0, 1'b0, 1'b0, 4'h3);
      exp_t[4]  = ev(2'b10, 1'b0, 1'b0, 1'b0, 4'h3);
      exp_t[5]  = ev(2'b10, 1'b0, 1'b0, 1'b0, 4'h3);
      exp_t[6]  = ev(2'b11, 1'b1, 1'b1, 1'b0, 4'h3);
      exp_t[7]  = ev(2'b11, 1'b1, 1'b1, 1'b0, 4'hA);
      exp_t[8]  = ev(2'b01, 1'b0, 1'b1, 1'b0, 4'hA);
      exp_t[9]  = ev(2'b01, 1'b0, 1'b1, 1'b0, 4'hA);
      exp_t[10] = ev(2'b01, 1'b0, 1'b1, 1'b0, 4'hA);
      exp_t[11] = ev(2'b01, 1'b0, 1'b1, 1'b0, 4'hA);
      exp_t[12] = ev(2'b11, 1'b1, 1'b0, 1'b1, 4'hA);
      exp_t[13] = ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h7);
      // Cycle 1 is the interval right after the last reset edge.
      reset = 1'b0;
      en    = 1'b1;
      s0    = 4'h3;
      s1    = 4'hA;
      for (int c = 1; c <= 14; c++) begin
         if (c > 1) step();
         checks++;
         if (obs !== exp_t[c-1]) begin
            errors++;
            $display("FAIL steady_frame cycle %0d: got %h expected %h", c, obs,
                     exp_t[c-1]);
         end
         if (c == 4) s0 = 4'h7;
      end
   endtask

   task automatic test_no_tearing();
      for (int c = 15; c <= 18; c++) begin
         step();
         checks++;
         if (obs !== ev(2'b10, 1'b0, 1'b0, 1'b0, 4'h7)) begin
            errors++;
            $display("FAIL no_tearing cycle %0d: got %h expected %h", c, obs,
                     ev(2'b10, 1'b0, 1'b0, 1'b0, 4'h7));
         end
      end
   endtask

   task automatic test_enable_drop();
      logic [3:0] exp_s;
      // Cycles 19-20 BLANK1, cycle 21 first SHOW1 cycle.
      step();
      step();
      step();
      checks++;
      if (obs !== ev(2'b01, 1'b0, 1'b1, 1'b0, 4'hA)) begin
         errors++;
         $display("FAIL enable_pre_drop: got %h expected %h", obs,
                  ev(2'b01, 1'b0, 1'b1, 1'b0, 4'hA));
      end
      en = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         step();
         exp_s = (c == 1) ? 4'h7 : 4'h9;
         checks++;
         if (obs !== ev(2'b11, 1'b1, 1'b0, 1'b0, exp_s)) begin
            errors++;
            $display("FAIL enable_low cycle %0d: got %h expected %h", c, obs,
                     ev(2'b11, 1'b1, 1'b0, 1'b0, exp_s));
         end
         if (c == 1) s0 = 4'h9;
      end
      en = 1'b1;
      step();
      checks++;
      if (obs !== ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h9)) begin
         errors++;
         $display("FAIL enable_reentry_blank: got %h expected %h", obs,
                  ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h9));
      end
      step();
      checks++;
      if (obs !== ev(2'b10, 1'b0, 1'b0, 1'b0, 4'h9)) begin
         errors++;
         $display("FAIL enable_reentry_show0: got %h expected %h", obs,
                  ev(2'b10, 1'b0, 1'b0, 1'b0, 4'h9));
      end
   endtask

   task automatic test_reset_mid_show();
      reset = 1'b1;
      step();
      checks++;
      if (obs !== ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h0)) begin
         errors++;
         $display("FAIL reset_mid_show0: got %h expected %h", obs,
                  ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h0));
      end
      reset = 1'b0;
      step();
      checks++;
      if (obs !== ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h9)) begin
         errors++;
         $display("FAIL reset_release_blank: got %h expected %h", obs,
                  ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h9));
      end
      step();
      checks++;
      if (obs !== ev(2'b10, 1'b0, 1'b0, 1'b0, 4'h9)) begin
         errors++;
         $display("FAIL reset_release_show0: got %h expected %h", obs,
                  ev(2'b10, 1'b0, 1'b0, 1'b0, 4'h9));
      end
   endtask

   task automatic test_simultaneous();
      // Reset together with en=0: reset values, s_out=0 rather than s0.
      reset = 1'b1;
      en    = 1'b0;
      step();
      checks++;
      if (obs !== ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h0)) begin
         errors++;
         $display("FAIL reset_with_en_low: got %h expected %h", obs,
                  ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h0));
      end
      reset = 1'b0;
      en    = 1'b1;
      for (int c = 2; c <= 12; c++) step();
      checks++;
      if (obs !== ev(2'b01, 1'b0, 1'b1, 1'b0, 4'hA)) begin
         errors++;
         $display("FAIL last_show1_cycle: got %h expected %h", obs,
                  ev(2'b01, 1'b0, 1'b1, 1'b0, 4'hA));
      end
      // Terminal count and en falling on the same edge: no frame_tick.
      en = 1'b0;
      step();
      checks++;
      if (obs !== ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h9)) begin
         errors++;
         $display("FAIL terminal_with_en_fall: got %h expected %h", obs,
                  ev(2'b11, 1'b1, 1'b0, 1'b0, 4'h9));
      end
      en = 1'b1;
   endtask

   task automatic test_default_frame();
      localparam int FRAME = 2 * (240 + 24000);
      int         first_tick;
      int         tick_count;
      logic [1:0] prev_an;
      first_tick = -1;
      tick_count = 0;
      reset_d    = 1'b0;
      prev_an    = an_d;
      // Bounded run: a missing tick shows up as a failed check below.
      for (int n = 1; n <= FRAME + 2; n++) begin
         step();
         checks++;
         if (an_d === 2'b00 || (an_d !== prev_an && an_d !== 2'b11 && prev_an !== 2'b11)) begin
            errors++;
            $display("FAIL default_an edge %0d: got %b after %b expected no 00 and change via 11",
                     n, an_d, prev_an);
         end
         prev_an = an_d;
         if (frame_tick_d === 1'b1) begin
            tick_count++;
            if (first_tick < 0) first_tick = n;
         end
      end
      checks++;
      if (first_tick !== FRAME) begin
         errors++;
         $display("FAIL default_frame_period: got %0d expected %0d", first_tick, FRAME);
      end
      checks++;
      if (tick_count !== 1) begin
         errors++;
         $display("FAIL default_tick_width: got %0d pulses expected %0d", tick_count, 1);
      end
   endtask

   initial begin
      reset   = 1'b1;
      en      = 1'b1;
      s0      = 4'h0;
      s1      = 4'h0;
      reset_d = 1'b1;
      en_d    = 1'b1;
      test_reset();
      test_steady_frame();
      test_no_tearing();
      test_enable_drop();
      test_reset_mid_show();
      test_simultaneous();
      test_default_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
